// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy/fill/compare engine:
// memory geometry, command encodings, FSM states and the latched command payload.
package mem_copy_engine_pkg;

    localparam int unsigned ISIZE = 16;
    localparam int unsigned DSIZE = 16;
    localparam int unsigned AW    = ISIZE;
    localparam int unsigned DW    = DSIZE;

    typedef enum logic [1:0] {
        OP_COPY = 2'd0,
        OP_FILL = 2'd1,
        OP_CMP  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CP_RD = 3'd1,
        ST_CP_WR = 3'd2,
        ST_FL_WR = 3'd3,
        ST_CM_A  = 3'd4,
        ST_CM_B  = 3'd5,
        ST_CM_C  = 3'd6,
        ST_DONE  = 3'd7
    } state_e;

    // Command fields captured when a start is accepted.
    typedef struct packed {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW-1:0] len;
        logic [DW-1:0] pattern;
    } cmd_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block COPY / FILL / COMPARE engine driving one single-port memory whose read
// data appears one cycle after the address is presented.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, op, src, dst,     command strobe and operands (sampled in IDLE only)
//   len, pattern
//   mem_wen, mem_addr,       memory initiator side
//   mem_wdata, mem_rdata
//   busy, done               status: busy in work states, done one-cycle pulse
//   mismatch_cnt,            COMPARE results, held until next accepted start
//   first_mismatch
module mem_copy_engine
    import mem_copy_engine_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW-1:0] len,
    input  logic [DW-1:0] pattern,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mismatch_cnt,
    output logic [AW-1:0] first_mismatch
);

    state_e        state_q;
    cmd_t          cmd_q;
    logic [AW-1:0] i_q;
    logic [DW-1:0] a_q;
    logic          wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          busy_q;
    logic          done_q;
    logic [AW-1:0] mcnt_q;
    logic [AW-1:0] first_q;

    logic          last_d;
    logic [AW-1:0] i_d;

    // Word i is the final one; offset for the next word.
    assign last_d = (i_q == AW'(cmd_q.len - AW'(1)));
    assign i_d    = AW'(i_q + AW'(1));

    // FSM; bus outputs are registered for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            i_q     <= '0;
            a_q     <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mcnt_q  <= '0;
            first_q <= '0;
        end else begin
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cmd_q.src     <= src;
                        cmd_q.dst     <= dst;
                        cmd_q.len     <= len;
                        cmd_q.pattern <= pattern;
                        i_q           <= '0;
                        mcnt_q        <= '0;
                        first_q       <= '1;
                        if (len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            case (op_e'(op))
                                OP_COPY: begin
                                    state_q <= ST_CP_RD;
                                    busy_q  <= 1'b1;
                                    addr_q  <= src;
                                end
                                OP_FILL: begin
                                    state_q <= ST_FL_WR;
                                    busy_q  <= 1'b1;
                                    wen_q   <= 1'b1;
                                    addr_q  <= dst;
                                    wdata_q <= pattern;
                                end
                                OP_CMP: begin
                                    state_q <= ST_CM_A;
                                    busy_q  <= 1'b1;
                                    addr_q  <= src;
                                end
                                default: begin
                                    state_q <= ST_DONE;
                                    done_q  <= 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_CP_RD: begin
                    state_q <= ST_CP_WR;
                    busy_q  <= 1'b1;
                    wen_q   <= 1'b1;
                    addr_q  <= AW'(cmd_q.dst + i_q);
                end
                ST_CP_WR: begin
                    i_q <= i_d;
                    if (last_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_CP_RD;
                        busy_q  <= 1'b1;
                        addr_q  <= AW'(cmd_q.src + i_d);
                    end
                end
                ST_FL_WR: begin
                    i_q <= i_d;
                    if (last_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                        wen_q   <= 1'b1;
                        addr_q  <= AW'(cmd_q.dst + i_d);
                        wdata_q <= cmd_q.pattern;
                    end
                end
                ST_CM_A: begin
                    state_q <= ST_CM_B;
                    busy_q  <= 1'b1;
                    addr_q  <= AW'(cmd_q.dst + i_q);
                end
                ST_CM_B: begin
                    // Read data here belongs to the A-side address of CM_A.
                    a_q     <= mem_rdata;
                    state_q <= ST_CM_C;
                    busy_q  <= 1'b1;
                    addr_q  <= AW'(cmd_q.dst + i_q);
                end
                ST_CM_C: begin
                    if (mem_rdata != a_q) begin
                        mcnt_q <= AW'(mcnt_q + AW'(1));
                        if (mcnt_q == '0) begin
                            first_q <= i_q;
                        end
                    end
                    i_q <= i_d;
                    if (last_d) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_CM_A;
                        busy_q  <= 1'b1;
                        addr_q  <= AW'(cmd_q.src + i_d);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Copy write data is the read data returning this cycle, passed straight through.
    assign mem_wdata      = (state_q == ST_CP_WR) ? mem_rdata : wdata_q;
    assign mem_wen        = wen_q;
    assign mem_addr       = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign mismatch_cnt   = mcnt_q;
    assign first_mismatch = first_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Testbench for mem_copy_engine: behavioural single-port memory with one-cycle
// registered-address read, a reference memory image, and a write scoreboard.
module tb_mem_copy_engine;
    import mem_copy_engine_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic [15:0] pattern;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] mismatch_cnt;
    logic [15:0] first_mismatch;

    int n_tests;
    int n_fail;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_wr[$];

    logic [15:0] mem   [0:65535];
    logic [15:0] model [0:65535];
    logic [15:0] rd_addr_q;
    logic        pre_wen;
    logic [15:0] pre_addr;
    logic [15:0] pre_data;

    mem_copy_engine dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op             (op),
        .src            (src),
        .dst            (dst),
        .len            (len),
        .pattern        (pattern),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .done           (done),
        .mismatch_cnt   (mismatch_cnt),
        .first_mismatch (first_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: bench preload port has priority; read data from registered address.
    always @(posedge clk) begin
        if (pre_wen) mem[pre_addr] <= pre_data;
        else if (mem_wen) mem[mem_addr] <= mem_wdata;
        rd_addr_q <= mem_addr;
    end
    assign mem_rdata = mem[rd_addr_q];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every engine write must match the next predicted write.
    always @(negedge clk) begin
        if (!rst && mem_wen) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(mem_wen), 32'd0);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(w.addr));
                check("wr_data", 32'(mem_wdata), 32'(w.data));
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_wen  = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_wen  = 1'b0;
        model[a] = d;
    endtask

    // Reference behaviour: forward-order word writes into the model image.
    task automatic predict(input logic [1:0] o, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input logic [15:0] p);
        for (int k = 0; k < int'(l); k++) begin
            logic [15:0] wa;
            logic [15:0] wd;
            wa = 16'(d + 16'(k));
            if (o == OP_COPY) wd = model[16'(s + 16'(k))];
            else              wd = p;
            if (o == OP_COPY || o == OP_FILL) begin
                model[wa] = wd;
                exp_wr.push_back('{addr: wa, data: wd});
            end
        end
    endtask

    task automatic cmp_model(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                             output logic [15:0] cnt, output logic [15:0] first);
        cnt   = '0;
        first = '1;
        for (int k = 0; k < int'(l); k++) begin
            if (model[16'(s + 16'(k))] != model[16'(d + 16'(k))]) begin
                if (cnt == '0) first = 16'(k);
                cnt = 16'(cnt + 16'd1);
            end
        end
    endtask

    // Issue one command, measure start-to-done latency, optionally pulse start
    // mid-command, and always pulse start in the DONE cycle (both must be ignored).
    task automatic run_cmd(input string tag, input logic [1:0] o, input logic [15:0] s,
                           input logic [15:0] d, input logic [15:0] l, input logic [15:0] p,
                           input int exp_lat, input int glitch_cyc);
        int cyc;
        predict(o, s, d, l, p);
        @(negedge clk);
        op = o; src = s; dst = d; len = l; pattern = p; start = 1'b1;
        @(posedge clk);
        cyc = 1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (done || cyc >= 400) break;
            check({tag, "_busy"}, 32'(busy), 32'd1);
            if (cyc == glitch_cyc) begin
                start = 1'b1; op = OP_FILL; dst = s; len = 16'd2; pattern = 16'hDEAD;
            end
            @(posedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        start = 1'b1; op = OP_FILL; dst = 16'h0090; len = 16'd1; pattern = 16'hBEEF;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_writes_left"}, 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic check_region(input string tag, input logic [15:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            check(tag, 32'(mem[16'(base + 16'(k))]), 32'(model[16'(base + 16'(k))]));
        end
    endtask

    initial begin
        logic [15:0] ecnt;
        logic [15:0] efirst;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; start = 1'b0; op = '0; src = '0; dst = '0; len = '0; pattern = '0;
        pre_wen = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wen", 32'(mem_wen), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_mcnt", 32'(mismatch_cnt), 32'd0);
        check("rst_first", 32'(first_mismatch), 32'd0);
        rst = 1'b0;

        preload(16'h0010, 16'h1111);
        preload(16'h0011, 16'h2222);
        preload(16'h0012, 16'h3333);
        preload(16'h0013, 16'h4444);
        preload(16'h0083, 16'h5A5A);

        run_cmd("copy", OP_COPY, 16'h0010, 16'h0040, 16'd4, 16'h0, 9, 0);
        check_region("copy_mem", 16'h0040, 4);
        check("copy_word3", 32'(mem[16'h0043]), 32'h4444);

        run_cmd("fill", OP_FILL, 16'h0000, 16'h0080, 16'd3, 16'hABCD, 4, 0);
        check_region("fill_mem", 16'h0080, 3);
        check("fill_word0", 32'(mem[16'h0080]), 32'hABCD);
        check("fill_untouched", 32'(mem[16'h0083]), 32'h5A5A);

        preload(16'h0042, 16'h0000);
        cmp_model(16'h0010, 16'h0040, 16'd4, ecnt, efirst);
        run_cmd("cmp_diff", OP_CMP, 16'h0010, 16'h0040, 16'd4, 16'h0, 13, 0);
        check("cmp_diff_cnt", 32'(mismatch_cnt), 32'(ecnt));
        check("cmp_diff_first", 32'(first_mismatch), 32'(efirst));

        preload(16'h0042, 16'h3333);
        cmp_model(16'h0010, 16'h0040, 16'd4, ecnt, efirst);
        run_cmd("cmp_same", OP_CMP, 16'h0010, 16'h0040, 16'd4, 16'h0, 13, 0);
        check("cmp_same_cnt", 32'(mismatch_cnt), 32'(ecnt));
        check("cmp_same_first", 32'(first_mismatch), 32'(efirst));

        run_cmd("zero_len", OP_COPY, 16'h0010, 16'h0040, 16'd0, 16'h0, 1, 0);
        check("zero_first", 32'(first_mismatch), 32'hFFFF);
        run_cmd("op_rsvd", OP_RSVD, 16'h0010, 16'h0040, 16'd5, 16'h0, 1, 0);

        run_cmd("wrap", OP_FILL, 16'h0000, 16'hFFFE, 16'd3, 16'h1234, 4, 0);
        check("wrap_ffff", 32'(mem[16'hFFFF]), 32'h1234);
        check("wrap_0000", 32'(mem[16'h0000]), 32'h1234);

        run_cmd("busy_start", OP_COPY, 16'h0010, 16'h0050, 16'd4, 16'h0, 9, 3);
        check_region("busy_start_mem", 16'h0050, 4);
        check("busy_start_src", 32'(mem[16'h0010]), 32'h1111);

        run_cmd("overlap", OP_COPY, 16'h0040, 16'h0041, 16'd3, 16'h0, 7, 0);
        check_region("overlap_mem", 16'h0040, 4);

        // Abort a COPY between clock edges.
        predict(OP_COPY, 16'h0010, 16'h0060, 16'd4, 16'h0);
        @(negedge clk);
        op = OP_COPY; src = 16'h0010; dst = 16'h0060; len = 16'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_wen", 32'(mem_wen), 32'd0);
        check("abort_addr", 32'(mem_addr), 32'd0);
        check("abort_wdata", 32'(mem_wdata), 32'd0);
        check("abort_mcnt", 32'(mismatch_cnt), 32'd0);
        check("abort_first", 32'(first_mismatch), 32'd0);
        check("abort_kept_word0", 32'(mem[16'h0060]), 32'h1111);
        exp_wr.delete();
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done_after", 32'(done), 32'd0);

        run_cmd("copy_after_rst", OP_COPY, 16'h0010, 16'h0060, 16'd4, 16'h0, 9, 0);
        check_region("copy_after_rst_mem", 16'h0060, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
